// File: rtl/axis_sa_os_gemm_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) shared by the GEMM engine's operand and
// result ports.
interface axis_sa_os_gemm_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sa_os_gemm.sv
// Output-stationary P x Q systolic GEMM engine: operands in and results out over AXI-Stream.
// Define SA_OS_SAT_EN to saturate results to the signed OW range instead of wrapping.
module axis_sa_os_gemm #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 32,
  parameter int unsigned OW   = 16,
  parameter int unsigned P    = 8,
  parameter int unsigned Q    = 8,
  parameter int unsigned KMAX = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cfg_m,
  input  logic [7:0]              cfg_n,
  input  logic [7:0]              cfg_k,
  input  logic                    cfg_acc,
  input  logic                    cfg_last,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err_len,
  axis_sa_os_gemm_if.slave        s_axis,
  axis_sa_os_gemm_if.master       m_axis
);
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned KW = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam logic [7:0]  P8 = 8'(P);
  localparam logic [7:0]  Q8 = 8'(Q);
  localparam logic [7:0]  K8 = 8'(KMAX);

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StWrite} state_e;

  state_e state_q, state_d;

  logic [7:0]  m_q, n_q, k_q, r_q, c_q, nr, nc, row_end;
  logic        acc_en_q, last_q, err_q;
  logic [15:0] t_q;
  logic [OW-1:0] od_q;
  logic        ov_q, ol_q;

  logic signed [DW-1:0]   a_buf [P][KMAX];
  logic signed [DW-1:0]   b_buf [KMAX][Q];
  logic signed [DW-1:0]   a_pipe [P][Q];
  logic signed [DW-1:0]   b_pipe [P][Q];
  logic signed [DW-1:0]   pe_a [P][Q];
  logic signed [DW-1:0]   pe_b [P][Q];
  logic signed [2*DW-1:0] prod [P][Q];
  logic signed [AW-1:0]   acc [P][Q];

  logic cfg_ok, beat, row_wrap, load_a_end, load_b_end, comp_end, at_last, wr_end;
  int   ki;

  function automatic logic [OW-1:0] narrow(input logic signed [AW-1:0] v);
`ifdef SA_OS_SAT_EN
    logic signed [AW-1:0] sat_max, sat_min;
    sat_max = AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    sat_min = ~sat_max;
    if (v > sat_max) return sat_max[OW-1:0];
    if (v < sat_min) return sat_min[OW-1:0];
    return OW'(v);
`else
    return OW'(v);
`endif
  endfunction

  always_comb begin
    cfg_ok = (cfg_m != 8'd0) && (cfg_m <= P8) && (cfg_n != 8'd0) && (cfg_n <= Q8) &&
             (cfg_k != 8'd0) && (cfg_k <= K8);
    beat       = s_axis.tvalid && (state_q == StLoadA || state_q == StLoadB);
    row_end    = (state_q == StLoadA) ? k_q - 8'd1 : n_q - 8'd1;
    row_wrap   = (c_q == row_end);
    nc         = row_wrap ? 8'd0 : c_q + 8'd1;
    nr         = row_wrap ? r_q + 8'd1 : r_q;
    load_a_end = beat && state_q == StLoadA && r_q == m_q - 8'd1 && row_wrap;
    load_b_end = beat && state_q == StLoadB && r_q == k_q - 8'd1 && row_wrap;
    comp_end   = (state_q == StCompute) && (t_q == 16'(k_q) + 16'(P + Q - 2));
    at_last    = (r_q == m_q - 8'd1) && (c_q == n_q - 8'd1);
    wr_end     = (state_q == StWrite) && ov_q && ol_q && m_axis.tready;
  end

  // Skewed edge feed plus neighbour forwarding: PE(i,j) sees k = t-i-j at cycle t.
  always_comb begin
    ki = 0;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < Q; j++) begin
        pe_a[i][j] = '0;
        pe_b[i][j] = '0;
      end
    end
    for (int i = 0; i < P; i++) begin
      ki = int'(t_q) - i;
      if (state_q == StCompute && i < int'(m_q) && ki >= 0 && ki < int'(k_q)) begin
        pe_a[i][0] = a_buf[i][ki[KW-1:0]];
      end
      for (int j = 1; j < Q; j++) pe_a[i][j] = a_pipe[i][j-1];
    end
    for (int j = 0; j < Q; j++) begin
      ki = int'(t_q) - j;
      if (state_q == StCompute && j < int'(n_q) && ki >= 0 && ki < int'(k_q)) begin
        pe_b[0][j] = b_buf[ki[KW-1:0]][j];
      end
      for (int i = 1; i < P; i++) pe_b[i][j] = b_pipe[i-1][j];
    end
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < Q; j++) begin
        prod[i][j] = (2*DW)'(pe_a[i][j]) * (2*DW)'(pe_b[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start && cfg_ok) state_d = StLoadA;
      StLoadA:   if (load_a_end) state_d = StLoadB;
      StLoadB:   if (load_b_end) state_d = StCompute;
      StCompute: if (comp_end) state_d = last_q ? StWrite : StIdle;
      StWrite:   if (wr_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = comp_end;
    err_len       = err_q;
    s_axis.tready = (state_q == StLoadA) || (state_q == StLoadB);
    m_axis.tvalid = ov_q;
    m_axis.tdata  = od_q;
    m_axis.tlast  = ol_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; n_q <= '0; k_q <= '0; r_q <= '0; c_q <= '0; t_q <= '0;
      acc_en_q <= 1'b0; last_q <= 1'b0; err_q <= 1'b0;
      od_q <= '0; ov_q <= 1'b0; ol_q <= 1'b0;
      for (int i = 0; i < P; i++) for (int k = 0; k < KMAX; k++) a_buf[i][k] <= '0;
      for (int k = 0; k < KMAX; k++) for (int j = 0; j < Q; j++) b_buf[k][j] <= '0;
      for (int i = 0; i < P; i++) begin
        for (int j = 0; j < Q; j++) begin
          a_pipe[i][j] <= '0; b_pipe[i][j] <= '0; acc[i][j] <= '0;
        end
      end
    end else begin
      if (state_q == StIdle && start) begin
        r_q <= '0;
        c_q <= '0;
        if (cfg_ok) begin
          m_q <= cfg_m; n_q <= cfg_n; k_q <= cfg_k;
          acc_en_q <= cfg_acc; last_q <= cfg_last; err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (beat) begin
        if (state_q == StLoadA) a_buf[r_q[PW-1:0]][c_q[KW-1:0]] <= s_axis.tdata;
        else                    b_buf[r_q[KW-1:0]][c_q[QW-1:0]] <= s_axis.tdata;
        // The beat count, not tlast, decides where each matrix ends.
        if (s_axis.tlast != (load_a_end || load_b_end)) err_q <= 1'b1;
        if (load_a_end || load_b_end) begin
          r_q <= '0; c_q <= '0;
        end else begin
          r_q <= nr; c_q <= nc;
        end
      end
      if (state_q == StCompute) begin
        t_q <= t_q + 16'd1;
        for (int i = 0; i < P; i++) begin
          for (int j = 0; j < Q; j++) begin
            a_pipe[i][j] <= pe_a[i][j];
            b_pipe[i][j] <= pe_b[i][j];
            acc[i][j]    <= acc[i][j] + AW'(prod[i][j]);
          end
        end
      end else begin
        t_q <= '0;
        for (int i = 0; i < P; i++) begin
          for (int j = 0; j < Q; j++) begin
            a_pipe[i][j] <= '0; b_pipe[i][j] <= '0;
            if (load_b_end && !acc_en_q) acc[i][j] <= '0;
          end
        end
      end
      if (state_q == StWrite) begin
        if (!ov_q) begin
          od_q <= narrow(acc[r_q[PW-1:0]][c_q[QW-1:0]]);
          ov_q <= 1'b1;
          ol_q <= at_last;
        end else if (m_axis.tready) begin
          if (ol_q) begin
            ov_q <= 1'b0;
            ol_q <= 1'b0;
          end else begin
            r_q  <= nr;
            c_q  <= nc;
            od_q <= narrow(acc[nr[PW-1:0]][nc[QW-1:0]]);
            ol_q <= (nr == m_q - 8'd1) && (nc == n_q - 8'd1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_sa_os_gemm.sv
// Directed bench for axis_sa_os_gemm: matrix-level reference model plus per-beat output checker.
module tb_axis_sa_os_gemm;
  localparam int DW = 8, AW = 32, OW = 16, P = 8, Q = 8, KMAX = 64;
`ifdef SA_OS_SAT_EN
  localparam logic [OW-1:0] FullExp = 16'h8000;
`else
  localparam logic [OW-1:0] FullExp = 16'h2000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic cfg_acc = 1'b0, cfg_last = 1'b0, start = 1'b0;
  logic busy, done, err_len;

  axis_sa_os_gemm_if #(.W(DW)) s_if ();
  axis_sa_os_gemm_if #(.W(OW)) m_if ();

  axis_sa_os_gemm #(.DW(DW), .AW(AW), .OW(OW), .P(P), .Q(Q), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
    .cfg_last(cfg_last), .start(start), .busy(busy), .done(done), .err_len(err_len),
    .s_axis(s_if), .m_axis(m_if)
  );

  typedef struct {logic [OW-1:0] d; logic l;} beat_t;

  int tests = 0, fails = 0;
  int a_m [P][KMAX];
  int b_m [KMAX][Q];
  int acc_m [P][Q];
  beat_t exp_q[$];
  logic [OW-1:0] rx[$];
  int done_cnt = 0;
  int rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp,
               exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] narrow(input int v);
`ifdef SA_OS_SAT_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[OW-1:0];
  endfunction

  // C = A x B over the live MxN window, then queue the row-major output stream if emitted.
  task automatic model_pass(input int m, input int n, input int k, input bit acc, input bit last);
    beat_t e;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < Q; j++)
        if (!acc) acc_m[i][j] = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) acc_m[i][j] = acc_m[i][j] + a_m[i][kk] * b_m[kk][j];
    if (last) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          e.d = narrow(acc_m[i][j]);
          e.l = (i == m - 1) && (j == n - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
    end
  end

  // Output checker: every transfer against the model queue, plus hold-while-stalled.
  logic stall_prev = 1'b0;
  logic [OW-1:0] prev_d = '0;
  logic prev_l = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (m_if.tvalid) begin
        if (stall_prev) begin
          chk("stall_tdata", m_if.tdata, prev_d);
          chk("stall_tlast", m_if.tlast, prev_l);
        end
        if (m_if.tready) begin
          rx.push_back(m_if.tdata);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("c_tdata", m_if.tdata, e.d);
            chk("c_tlast", m_if.tlast, e.l);
          end
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      prev_d = m_if.tdata;
      prev_l = m_if.tlast;
    end
  end

  task automatic start_job(input int m, input int n, input int k, input bit acc, input bit last);
    cfg_m = 8'(m); cfg_n = 8'(n); cfg_k = 8'(k); cfg_acc = acc; cfg_last = last;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit gap);
    bit ok;
    int n;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_if.tdata = d; s_if.tlast = last; s_if.tvalid = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic send_mats(input int m, input int n, input int k, input bit gap, input int a_tl);
    for (int i = 0; i < m; i++)
      for (int kk = 0; kk < k; kk++) send_beat(8'(a_m[i][kk]), (i * k + kk) == a_tl, gap);
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < n; j++) send_beat(8'(b_m[kk][j]), (kk * n + j) == k * n - 1, gap);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == budget) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int m, input int n, input int k, input bit acc, input bit last,
                          input bit gap, input int a_tl, input bit exp_err);
    model_pass(m, n, k, acc, last);
    done_cnt = 0;
    start_job(m, n, k, acc, last);
    send_mats(m, n, k, gap, a_tl);
    wait_idle(3000);
    chk("done_once", done_cnt, 1);
    chk("err_len", err_len, exp_err);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic load_2x2();
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    for (int i = 0; i < P; i++) for (int j = 0; j < Q; j++) acc_m[i][j] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_len, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_s_tready", s_if.tready, 0);
    rst = 1'b0;

    // Out-of-range configuration stays in IDLE and flags err_len.
    start_job(0, 2, 2, 0, 1);
    chk("badcfg_err", err_len, 1);
    chk("badcfg_busy", busy, 0);

    // 2x2x2 basic job.
    load_2x2();
    rdy_mode = 1;
    rx.delete();
    run_pass(2, 2, 2, 0, 1, 0, 3, 0);
    chk("basic_beats", rx.size(), 4);
    if (rx.size() == 4) begin
      chk("basic_c00", rx[0], 19);
      chk("basic_c01", rx[1], 22);
      chk("basic_c10", rx[2], 43);
      chk("basic_c11", rx[3], 50);
    end

    // Full array, K = KMAX, extreme operands.
    for (int i = 0; i < P; i++) for (int kk = 0; kk < KMAX; kk++) a_m[i][kk] = 127;
    for (int kk = 0; kk < KMAX; kk++) for (int j = 0; j < Q; j++) b_m[kk][j] = -128;
    rx.delete();
    run_pass(P, Q, KMAX, 0, 1, 0, P * KMAX - 1, 0);
    chk("full_beats", rx.size(), P * Q);
    if (rx.size() > 0) chk("full_c00", rx[0], FullExp);
    if (rx.size() == P * Q) chk("full_clast", rx[P*Q-1], FullExp);

    // Two-pass accumulation: first pass silent, second emits the sum.
    load_2x2();
    rx.delete();
    run_pass(2, 2, 2, 0, 0, 0, 3, 0);
    chk("pass1_silent", rx.size(), 0);
    run_pass(2, 2, 2, 1, 1, 0, 3, 0);
    chk("pass2_beats", rx.size(), 4);
    if (rx.size() == 4) begin
      chk("pass2_c00", rx[0], 38);
      chk("pass2_c01", rx[1], 44);
      chk("pass2_c10", rx[2], 86);
      chk("pass2_c11", rx[3], 100);
    end

    // 3x5x4 (M x N x K) with gapped input and random backpressure.
    for (int i = 0; i < 3; i++) for (int kk = 0; kk < 4; kk++)
      a_m[i][kk] = int'($urandom_range(0, 255)) - 128;
    for (int kk = 0; kk < 4; kk++) for (int j = 0; j < 5; j++)
      b_m[kk][j] = int'($urandom_range(0, 255)) - 128;
    rdy_mode = 2;
    rx.delete();
    run_pass(3, 5, 4, 0, 1, 1, 11, 0);
    chk("rand_beats", rx.size(), 15);
    rdy_mode = 1;

    // Early tlast on A: flagged, but the beat count still drives the job.
    load_2x2();
    rx.delete();
    run_pass(2, 2, 2, 0, 1, 0, 2, 1);
    chk("early_tlast_c11", (rx.size() == 4) ? longint'(rx[3]) : -1, 50);
    start_job(2, 2, 2, 0, 1);
    chk("err_cleared_on_start", err_len, 0);
    model_pass(2, 2, 2, 0, 1);
    send_mats(2, 2, 2, 0, 3);
    wait_idle(3000);

    // Reset in the middle of WRITE.
    rdy_mode = 0;
    begin
      int n;
      model_pass(2, 2, 2, 0, 1);
      start_job(2, 2, 2, 0, 1);
      send_mats(2, 2, 2, 0, 3);
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (m_if.tvalid) break;
      end
      chk("write_reached", m_if.tvalid, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tvalid", m_if.tvalid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < P; i++) for (int j = 0; j < Q; j++) acc_m[i][j] = 0;
    rdy_mode = 1;
    rx.delete();
    run_pass(2, 2, 2, 0, 1, 0, 3, 0);
    chk("post_rst_c00", (rx.size() > 0) ? longint'(rx[0]) : -1, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
